fetch_decode_skid_reg: RTL and testbench

- Next-generation Fetch→Decode pipeline register with valid/ready handshake and a 2-entry skid buffer.
- Replaces the bare enable/clear register and supports back-pressure from Decode without a combinational ready path to Fetch.
- Flushed entries become a configurable NOP bubble instead of all-zeros.
- Sits between the fetch stage (PC/instruction memory) and the decode stage (register file/control unit).

---
 rtl/pipe_pkg.sv | 16 +
 rtl/fetch_decode_skid_reg_if.sv | 28 ++
 rtl/pipe_slot.sv | 20 ++
 rtl/fetch_decode_skid_reg.sv | 122 ++++++++++++
 tb/tb_fetch_decode_skid_reg.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the Fetch->Decode register and later stage registers.
//   pipe_state_t : occupancy of a two-slot (main + skid) stage register
//   RV_NOP       : addi x0,x0,0, the bubble inserted on reset/flush
//   fd_payload_t : {instr, pc, pcplus4}, same bit order as the packed slot payload
package pipe_pkg;
   localparam int unsigned XLEN   = 32;
   localparam logic [31:0] RV_NOP = 32'h00000013;

   typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcplus4;
   } fd_payload_t;
endpackage

// File: rtl/fetch_decode_skid_reg_if.sv
// Fetch->Decode handshake bundle.
//   F side : InstrF, PCF, PCPlus4F, ValidF (from fetch), ReadyF (to fetch)
//   D side : InstrD, PCD, PCPlus4D, ValidD (to decode), ReadyD (from decode)
// master = the surrounding pipeline (fetch + decode), slave = the stage register.
interface fetch_decode_skid_reg_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] InstrF;
   logic [DATA_WIDTH-1:0] PCF;
   logic [DATA_WIDTH-1:0] PCPlus4F;
   logic                  ValidF;
   logic                  ReadyF;
   logic [DATA_WIDTH-1:0] InstrD;
   logic [DATA_WIDTH-1:0] PCD;
   logic [DATA_WIDTH-1:0] PCPlus4D;
   logic                  ValidD;
   logic                  ReadyD;

   modport master (
      output InstrF, PCF, PCPlus4F, ValidF, ReadyD,
      input  ReadyF, InstrD, PCD, PCPlus4D, ValidD
   );

   modport slave (
      input  InstrF, PCF, PCPlus4F, ValidF, ReadyD,
      output ReadyF, InstrD, PCD, PCPlus4D, ValidD
   );
endinterface

// File: rtl/pipe_slot.sv
// Single payload register with load enable and synchronous clear-to-constant.
//   clk : rising-edge clock
//   clr : synchronous clear to CLR_VAL (wins over ld)
//   ld  : capture d
//   d/q : payload in/out
module pipe_slot #(
   parameter int unsigned W       = 96,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (clr)     q <= CLR_VAL;
      else if (ld) q <= d;
   end
endmodule

// File: rtl/fetch_decode_skid_reg.sv
// Fetch->Decode pipeline register with valid/ready handshake and a 2-entry
// skid buffer (main slot drives decode, skid slot absorbs one overflow beat).
// ReadyF is a function of the state register and RST/FLUSH only, so there is
// no combinational path from ReadyD to ReadyF.
//   CLK   : rising-edge clock
//   RST   : synchronous active-high reset
//   FLUSH : synchronous flush, same register effect as RST (RST has priority)
//   bus   : fetch_decode_skid_reg_if.slave (F payload in, D payload out)
//   StallCntD : present only with FD_STALL_CNT_EN defined; saturating count of
//               cycles with ValidD & ~ReadyD, cleared by RST only
module fetch_decode_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(RV_NOP),
   parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      FLUSH,
`ifdef FD_STALL_CNT_EN
   output logic [31:0]               StallCntD,
`endif
   fetch_decode_skid_reg_if.slave    bus
);
   localparam int unsigned  PW          = 3 * DATA_WIDTH;
   localparam logic [PW-1:0] CLR_PAYLOAD = {NOP_INSTR, PC_RESET, PC_RESET};

   pipe_state_t   state, state_nxt;
   logic          clr;
   logic          rdy_st, vld_st;
   logic          main_ld, main_clr, main_from_skid, skid_ld;
   logic [PW-1:0] f_payload, main_d, main_q, skid_q;

   assign clr       = RST | FLUSH;
   assign f_payload = {bus.InstrF, bus.PCF, bus.PCPlus4F};
   assign main_d    = main_from_skid ? skid_q : f_payload;

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state <= PS_EMPTY;
      else     state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      if (FLUSH) begin
         state_nxt = PS_EMPTY;
      end else begin
         case (state)
            PS_EMPTY: if (bus.ValidF) state_nxt = PS_BUSY;
            PS_BUSY: begin
               if (bus.ValidF && !bus.ReadyD)      state_nxt = PS_FULL;
               else if (!bus.ValidF && bus.ReadyD) state_nxt = PS_EMPTY;
            end
            PS_FULL:  if (bus.ReadyD) state_nxt = PS_BUSY;
            default:  state_nxt = PS_EMPTY;
         endcase
      end
   end

   // outputs / slot controls; clr overrides every load inside the slots
   always_comb begin
      rdy_st         = 1'b0;
      vld_st         = 1'b0;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      case (state)
         PS_EMPTY: begin
            rdy_st  = 1'b1;
            main_ld = bus.ValidF;
         end
         PS_BUSY: begin
            rdy_st   = 1'b1;
            vld_st   = 1'b1;
            main_ld  = bus.ValidF & bus.ReadyD;
            skid_ld  = bus.ValidF & ~bus.ReadyD;
            // main drained with nothing behind it: show the bubble, not stale data
            main_clr = ~bus.ValidF & bus.ReadyD;
         end
         PS_FULL: begin
            vld_st         = 1'b1;
            main_ld        = bus.ReadyD;
            main_from_skid = 1'b1;
         end
         default: ;
      endcase
   end

   pipe_slot #(.W(PW), .CLR_VAL(CLR_PAYLOAD)) u_main (
      .clk (CLK),
      .clr (clr | main_clr),
      .ld  (main_ld),
      .d   (main_d),
      .q   (main_q)
   );

   // skid contents are never visible while invalid; cleared only for tidiness
   pipe_slot #(.W(PW), .CLR_VAL(CLR_PAYLOAD)) u_skid (
      .clk (CLK),
      .clr (clr),
      .ld  (skid_ld),
      .d   (f_payload),
      .q   (skid_q)
   );

   assign bus.ReadyF = rdy_st & ~clr;
   assign bus.ValidD = vld_st;
   assign {bus.InstrD, bus.PCD, bus.PCPlus4D} = main_q;

`ifdef FD_STALL_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST)
         StallCntD <= '0;
      else if (vld_st && !bus.ReadyD && (StallCntD != 32'hFFFF_FFFF))
         StallCntD <= StallCntD + 32'd1;
   end
`endif
endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Bench for fetch_decode_skid_reg: directed scenarios then random traffic,
// checked every cycle against a queue model of the stage (0..2 payloads).
module tb_fetch_decode_skid_reg;
   import pipe_pkg::*;

   localparam logic [31:0] NOP = 32'h00000013;

   logic CLK = 1'b0;
   logic RST, FLUSH;
`ifdef FD_STALL_CNT_EN
   logic [31:0] StallCntD;
   logic [31:0] cnt_m = '0;
`endif

   fetch_decode_skid_reg_if #(.DATA_WIDTH(32)) bus ();

   fetch_decode_skid_reg #(.DATA_WIDTH(32)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .FLUSH (FLUSH),
`ifdef FD_STALL_CNT_EN
      .StallCntD (StallCntD),
`endif
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   fd_payload_t q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got %h expected %h (t=%0t)", tag, act, exp, $time);
   endtask

   // one clock: drive at negedge, check pre-edge outputs, advance the model
   task automatic step(input logic rst_i, input logic flush_i, input logic vf,
                       input logic rd, input logic [31:0] instr, input logic [31:0] pc);
      fd_payload_t exp_p;
      logic        exp_rdy, exp_vld;
      @(negedge CLK);
      RST = rst_i; FLUSH = flush_i;
      bus.ValidF = vf; bus.ReadyD = rd;
      bus.InstrF = instr; bus.PCF = pc; bus.PCPlus4F = pc + 32'd4;
      #1;
      exp_rdy = !rst_i && !flush_i && (q.size() < 2);
      exp_vld = (q.size() != 0);
      exp_p   = exp_vld ? q[0] : '{instr: NOP, pc: 32'h0, pcplus4: 32'h0};
      chk("ReadyF",   32'(bus.ReadyF), 32'(exp_rdy));
      chk("ValidD",   32'(bus.ValidD), 32'(exp_vld));
      chk("InstrD",   bus.InstrD,   exp_p.instr);
      chk("PCD",      bus.PCD,      exp_p.pc);
      chk("PCPlus4D", bus.PCPlus4D, exp_p.pcplus4);
`ifdef FD_STALL_CNT_EN
      chk("StallCntD", StallCntD, cnt_m);
      if (rst_i) cnt_m = '0;
      else if (exp_vld && !rd && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
`endif
      if (rst_i || flush_i) q.delete();
      else begin
         if (exp_vld && rd) void'(q.pop_front());
         if (vf && exp_rdy) q.push_back('{instr: instr, pc: pc, pcplus4: pc + 32'd4});
      end
   endtask

   task automatic after_edge();
      @(posedge CLK); #1;
   endtask

   initial begin
      RST = 1'b1; FLUSH = 1'b0;
      bus.ValidF = 1'b1; bus.ReadyD = 1'b0;
      bus.InstrF = '0; bus.PCF = '0; bus.PCPlus4F = '0;

      // reset held 2 cycles with ValidF asserted
      step(1, 0, 1, 0, 32'hDEAD_0001, 32'h100);
      step(1, 0, 1, 0, 32'hDEAD_0002, 32'h104);
      after_edge();
      chk("rst_validd", 32'(bus.ValidD), 32'h0);
      chk("rst_instrd", bus.InstrD, NOP);
      chk("rst_pcd",    bus.PCD,    32'h0);

      // streaming, no bubbles
      step(0, 0, 1, 1, 32'hA000_0000, 32'h00);
      step(0, 0, 1, 1, 32'hA000_0004, 32'h04);
      step(0, 0, 1, 1, 32'hA000_0008, 32'h08);
      step(0, 0, 0, 1, 32'h0, 32'h0);
      step(0, 0, 0, 1, 32'h0, 32'h0);

      // back-pressure fills the skid
      step(0, 0, 1, 0, 32'hB000_0010, 32'h10);
      step(0, 0, 1, 0, 32'hB000_0014, 32'h14);
      after_edge();
      chk("bp_pcd",    bus.PCD, 32'h10);
      chk("bp_readyf", 32'(bus.ReadyF), 32'h0);
      step(0, 0, 1, 0, 32'hB000_0018, 32'h18);
      step(0, 0, 0, 1, 32'h0, 32'h0);
      step(0, 0, 0, 1, 32'h0, 32'h0);
      step(0, 0, 0, 1, 32'h0, 32'h0);

      // flush while FULL drops both beats
      step(0, 0, 1, 0, 32'hC000_0020, 32'h20);
      step(0, 0, 1, 0, 32'hC000_0024, 32'h24);
      step(0, 1, 1, 0, 32'hC000_0028, 32'h28);
      after_edge();
      chk("fl_validd", 32'(bus.ValidD), 32'h0);
      chk("fl_instrd", bus.InstrD, NOP);
      step(0, 0, 0, 1, 32'h0, 32'h0);

      // flush with incoming beat in BUSY; then RST and FLUSH together
      step(0, 0, 1, 0, 32'hD000_0030, 32'h30);
      step(0, 1, 1, 0, 32'hD000_0034, 32'h34);
      step(0, 0, 1, 0, 32'hD000_0038, 32'h38);
      step(1, 1, 1, 0, 32'hD000_003C, 32'h3C);
      after_edge();
      chk("rf_validd", 32'(bus.ValidD), 32'h0);
      chk("rf_pcd",    bus.PCD, 32'h0);

      // 7 stall cycles, then flush (ReadyD=1), then reset
      step(0, 0, 1, 0, 32'hE000_0040, 32'h40);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
`ifdef FD_STALL_CNT_EN
      after_edge();
      chk("stall_7", StallCntD, 32'd7);
`endif
      step(0, 1, 0, 1, 32'h0, 32'h0);
`ifdef FD_STALL_CNT_EN
      after_edge();
      chk("stall_flush", StallCntD, 32'd7);
`endif
      step(1, 0, 0, 1, 32'h0, 32'h0);
`ifdef FD_STALL_CNT_EN
      after_edge();
      chk("stall_rst", StallCntD, 32'd0);
`endif

      // random traffic
      for (int i = 0; i < 500; i++) begin
         logic r, f, v, d;
         r = ($urandom_range(99) < 2);
         f = ($urandom_range(99) < 5);
         v = ($urandom_range(99) < 70);
         d = ($urandom_range(99) < 60);
         step(r, f, v, d, $urandom, $urandom & 32'hFFFF_FFFC);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
